// File: rtl/flash_write_sequencer_pkg.sv
// Shared definitions for the PRG flash write sequencer: FSM state
// encodings, JEDEC command bytes and command addresses.
package flash_write_sequencer_pkg;

  // State encodings IDLE=0 .. BUSY=7; the numeric values are visible on seq_state.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_U1   = 3'd1,
    ST_U2   = 3'd2,
    ST_PROG = 3'd3,
    ST_E0   = 3'd4,
    ST_E1   = 3'd5,
    ST_E2   = 3'd6,
    ST_BUSY = 3'd7
  } seq_state_e;

  // JEDEC command bytes.
  localparam logic [7:0] CMD_AA = 8'hAA;
  localparam logic [7:0] CMD_55 = 8'h55;
  localparam logic [7:0] CMD_A0 = 8'hA0;
  localparam logic [7:0] CMD_80 = 8'h80;
  localparam logic [7:0] CMD_10 = 8'h10;
  localparam logic [7:0] CMD_30 = 8'h30;
  localparam logic [7:0] CMD_F0 = 8'hF0;

  // Command addresses, held at full CPU width; only the low
  // CMD_ADDR_BITS bits take part in the comparison.
  localparam logic [14:0] CMD_ADDR_555 = 15'h0555;
  localparam logic [14:0] CMD_ADDR_2AA = 15'h02AA;

endpackage

// File: rtl/flash_write_sequencer_timer.sv
// Loadable saturating down-counter with a zero flag. Load has priority
// over counting; the count sticks at zero instead of wrapping.
module flash_write_sequencer_timer #(
  parameter int WIDTH = 6
) (
  input  logic             m2,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             count_en,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  // Count register: synchronous reset, load, else decrement while non-zero.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge m2) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count_en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/flash_write_sequencer.sv
// PRG flash write sequencer: recognises JEDEC program / erase command
// sequences on CPU writes to $8000-$FFFF and opens we_gate only for writes
// that belong to a valid sequence (or the F0 reset command).
// Optional feature: define FLASH_SEQ_TIMEOUT_EN to abort a half-entered
// sequence after TIMEOUT_CYCLES m2 edges without an accepted write.
module flash_write_sequencer
  import flash_write_sequencer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int BUSY_CYCLES    = 32,
  parameter int CMD_ADDR_BITS  = 11
) (
  input  logic        m2,
  input  logic        reset,
  input  logic        wr_strobe,
  input  logic [14:0] wr_addr,
  input  logic [7:0]  wr_data,
  input  logic        prg_write_enabled,
  output logic        we_gate,
  output logic        busy,
  output logic        armed,
  output logic        cmd_done,
  output logic        seq_abort,
  output logic [3:0]  seq_state
);

  localparam int                BUSY_W    = $clog2(BUSY_CYCLES) + 1;
  localparam logic [BUSY_W-1:0] BUSY_LOAD = BUSY_W'(BUSY_CYCLES - 1);

  seq_state_e state, next_state;
  logic       pass_c, done_c, abort_c;
  logic       at_555, at_2aa, is_f0;
  logic       busy_zero, busy_load;
  logic       timeout_hit;
  logic       unused_addr_bits;

  // Command-address matcher on the low address bits only; the upper CPU
  // address bits are deliberately don't-care.
  assign at_555 = (wr_addr[CMD_ADDR_BITS-1:0] == CMD_ADDR_555[CMD_ADDR_BITS-1:0]);
  assign at_2aa = (wr_addr[CMD_ADDR_BITS-1:0] == CMD_ADDR_2AA[CMD_ADDR_BITS-1:0]);
  assign is_f0  = (wr_data == CMD_F0);
  assign unused_addr_bits = ^wr_addr[14:CMD_ADDR_BITS];

  // Next-state decode; pass_c marks a write that is allowed through to flash.
  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    pass_c     = 1'b0;
    done_c     = 1'b0;
    abort_c    = 1'b0;
    if (!prg_write_enabled) begin
      next_state = ST_IDLE;
    end else if (wr_strobe && is_f0) begin
      next_state = ST_IDLE;
      pass_c     = 1'b1;
    end else if (state == ST_BUSY) begin
      // Other writes in BUSY are gated and ignored; only expiry leaves.
      if (busy_zero) begin
        next_state = ST_IDLE;
        done_c     = 1'b1;
      end
    end else if (wr_strobe) begin
      case (state)
        ST_IDLE: if (at_555 && wr_data == CMD_AA) begin next_state = ST_U1; pass_c = 1'b1; end
        ST_U1:   if (at_2aa && wr_data == CMD_55) begin next_state = ST_U2; pass_c = 1'b1; end
        ST_U2: begin
          if (at_555 && wr_data == CMD_A0) begin
            next_state = ST_PROG;
            pass_c     = 1'b1;
          end else if (at_555 && wr_data == CMD_80) begin
            next_state = ST_E0;
            pass_c     = 1'b1;
          end
        end
        ST_PROG: begin next_state = ST_BUSY; pass_c = 1'b1; end
        ST_E0:   if (at_555 && wr_data == CMD_AA) begin next_state = ST_E1; pass_c = 1'b1; end
        ST_E1:   if (at_2aa && wr_data == CMD_55) begin next_state = ST_E2; pass_c = 1'b1; end
        ST_E2: begin
          if ((at_555 && wr_data == CMD_10) || (wr_data == CMD_30)) begin
            next_state = ST_BUSY;
            pass_c     = 1'b1;
          end
        end
        default: ;
      endcase
      // A rejected write mid-sequence aborts; in IDLE it is simply dropped.
      if (state != ST_IDLE && !pass_c) begin
        next_state = ST_IDLE;
        abort_c    = 1'b1;
      end
    end else if (timeout_hit) begin
      next_state = ST_IDLE;
      abort_c    = 1'b1;
    end
  end

  assign we_gate   = pass_c;
  assign seq_state = {1'b0, state};

  // FSM state and registered status outputs, all derived from next_state.
  always_ff @(posedge m2) begin
    if (reset) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      armed     <= 1'b0;
      cmd_done  <= 1'b0;
      seq_abort <= 1'b0;
    end else begin
      state     <= next_state;
      busy      <= (next_state == ST_BUSY);
      armed     <= (next_state != ST_IDLE) && (next_state != ST_BUSY);
      cmd_done  <= done_c;
      seq_abort <= abort_c;
    end
  end

  // Loaded on BUSY entry with BUSY_CYCLES-1 so BUSY lasts exactly BUSY_CYCLES edges.
  assign busy_load = (next_state == ST_BUSY) && (state != ST_BUSY);

  flash_write_sequencer_timer #(.WIDTH(BUSY_W)) u_busy_timer (
    .m2         (m2),
    .reset      (reset),
    .load       (busy_load),
    .load_value (BUSY_LOAD),
    .count_en   (busy),
    .zero       (busy_zero)
  );

`ifdef FLASH_SEQ_TIMEOUT_EN
  localparam int            TO_W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT_CYCLES - 1);

  logic timeout_zero;

  // Restarted by every accepted write; runs only while armed.
  flash_write_sequencer_timer #(.WIDTH(TO_W)) u_timeout_timer (
    .m2         (m2),
    .reset      (reset),
    .load       (pass_c),
    .load_value (TO_LOAD),
    .count_en   (armed),
    .zero       (timeout_zero)
  );

  assign timeout_hit = armed & timeout_zero;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

  assign timeout_hit = 1'b0;
`endif

endmodule
